// File: rtl/frac_div_pkg.sv
// Shared types for the fractional clock divider: FSM states, default field
// width and the num/den config record.
package frac_div_pkg;

    localparam int CW_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_LOAD,
        S_STOP
    } state_t;

    // Shadow config record; the divider's CW may be at most CW_DEF.
    typedef struct packed {
        logic [CW_DEF-1:0] num;
        logic [CW_DEF-1:0] den;
    } cfg_t;

    function automatic logic cfg_legal(input logic [CW_DEF-1:0] num, input logic [CW_DEF-1:0] den);
        return (num != '0) && (num <= den);
    endfunction

endpackage

// File: rtl/frac_div_if.sv
// Config offer handshake between a config source and frac_div_ctrl.
interface frac_div_if #(parameter int CW = 16) ();

    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_num;
    logic [CW-1:0] cfg_den;

    modport master (output cfg_valid, output cfg_num, output cfg_den, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_num, input cfg_den, output cfg_ready);

endinterface

// File: rtl/frac_div_core.sv
// Phase-accumulator engine: acc += N each step, wrap by D toggles clk_out.
module frac_div_core #(
    parameter int CW = 16
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          step,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] num_in,
    input  logic [CW-1:0] den_in,
    output logic          clk_out,
    output logic          tick
);

    logic [CW-1:0] n_q, d_q;
    logic [CW:0]   acc, sum;
    logic          wrap;

    // acc < D and N <= D, so one extra bit holds acc+N without overflow.
    assign sum  = acc + {1'b0, n_q};
    assign wrap = sum >= {1'b0, d_q};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            n_q     <= '0;
            d_q     <= '0;
            acc     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                n_q <= num_in;
                d_q <= den_in;
                acc <= '0;
            end else if (clear) begin
                acc <= '0;
            end else if (step) begin
                if (wrap) begin
                    acc     <= sum - {1'b0, d_q};
                    clk_out <= ~clk_out;
                    tick    <= ~clk_out;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional clock divider controller: config handshake, shadow config and
// run/drain/load/stop sequencing. Optional FRAC_DIV_CFG_ERR_EN adds cfg_err.
module frac_div_ctrl
    import frac_div_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic     clk_in,
    input  logic     reset,
    input  logic     en,
    frac_div_if.slave cfg,
    output logic     clk_out,
    output logic     tick,
    output logic     busy
`ifdef FRAC_DIV_CFG_ERR_EN
    ,output logic    cfg_err
`endif
);

    state_t state, state_nxt;
    cfg_t   shadow;
    logic   loaded;
    logic   xfer, legal, take;
    logic   step, clear, load;

    assign xfer  = cfg.cfg_valid & cfg.cfg_ready;
    assign legal = cfg_legal(CW_DEF'(cfg.cfg_num), CW_DEF'(cfg.cfg_den));
    // Illegal offers are consumed but never reach the FSM or the shadow.
    assign take  = xfer & legal;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (take) state_nxt = S_LOAD;
                     else if (en && loaded) state_nxt = S_RUN;
            S_RUN:   if (take) state_nxt = S_DRAIN;
                     else if (!en) state_nxt = S_STOP;
            S_DRAIN: if (!clk_out) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = en ? S_RUN : S_IDLE;
            S_STOP:  if (!clk_out) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            shadow        <= '0;
            loaded        <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b0;
`ifdef FRAC_DIV_CFG_ERR_EN
            cfg_err       <= 1'b0;
`endif
        end else begin
            if (take) shadow <= '{num: CW_DEF'(cfg.cfg_num), den: CW_DEF'(cfg.cfg_den)};
            if (state == S_LOAD) loaded <= 1'b1;
`ifdef FRAC_DIV_CFG_ERR_EN
            if (xfer) cfg_err <= ~legal;
`endif
            state         <= state_nxt;
            cfg.cfg_ready <= (state_nxt == S_IDLE) || (state_nxt == S_RUN);
            busy          <= (state_nxt == S_DRAIN) || (state_nxt == S_LOAD) || (state_nxt == S_STOP);
        end
    end

    // DRAIN and STOP only advance while high so a high phase always completes.
    assign step  = (state == S_RUN) || (((state == S_DRAIN) || (state == S_STOP)) && clk_out);
    assign clear = (state == S_STOP) && !clk_out;
    assign load  = (state == S_LOAD);

    frac_div_core #(.CW(CW)) u_core (
        .clk_in  (clk_in),
        .reset   (reset),
        .step    (step),
        .clear   (clear),
        .load    (load),
        .num_in  (shadow.num[CW-1:0]),
        .den_in  (shadow.den[CW-1:0]),
        .clk_out (clk_out),
        .tick    (tick)
    );

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Directed bench for frac_div_ctrl: ratios, reconfig drain, stop, illegal cfg, reset.
module tb_frac_div_ctrl;

    logic clk_in = 1'b0;
    logic reset;
    logic en;
    logic clk_out, tick, busy;
`ifdef FRAC_DIV_CFG_ERR_EN
    logic cfg_err;
`endif
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] co, tk, bz;

    frac_div_if #(.CW(16)) cfg_if ();

    frac_div_ctrl #(.CW(16)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .en      (en),
        .cfg     (cfg_if),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
`ifdef FRAC_DIV_CFG_ERR_EN
        ,.cfg_err (cfg_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_cfg(input logic [15:0] n, input logic [15:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_num   = n;
        cfg_if.cfg_den   = d;
        cyc();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // bit i of each vector = output sampled after the (i+1)th edge
    task automatic collect(input int n, output logic [31:0] c, output logic [31:0] t, output logic [31:0] b);
        c = '0; t = '0; b = '0;
        for (int i = 0; i < n; i++) begin
            cyc();
            c[i] = clk_out;
            t[i] = tick;
            b[i] = busy;
        end
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_num = '0;
        cfg_if.cfg_den = '0;
        cyc(); cyc();
        chk("rst_clk", {31'd0, clk_out}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, cfg_if.cfg_ready}, 32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_rdy", {31'd0, cfg_if.cfg_ready}, 32'd1);

        // N=2 D=3: toggles on steps 2,3,5,6,8,9
        en = 1'b1;
        send_cfg(16'd2, 16'd3);
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_rdy", {31'd0, cfg_if.cfg_ready}, 32'd0);
        cyc();
        chk("run_busy", {31'd0, busy}, 32'd0);
        collect(9, co, tk, bz);
        chk("n2d3_clk", co, 32'b010010010);
        chk("n2d3_tick", tk, 32'b010010010);

        // reconfig to N=5 D=5 while low: drain exits at once, then toggle per cycle
        send_cfg(16'd5, 16'd5);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        collect(6, co, tk, bz);
        chk("n5d5_clk", co, 32'b010100);
        chk("n5d5_tick", tk, 32'b010100);
        chk("n5d5_busy", bz, 32'b000001);

        // N=1 D=4: period 8, high 4
        send_cfg(16'd1, 16'd4);
        chk("n1d4_clk0", {31'd0, clk_out}, 32'd1);
        collect(12, co, tk, bz);
        chk("n1d4_clk", co, 32'b001111000000);
        chk("n1d4_tick", tk, 32'b000001000000);
        chk("n1d4_busy", bz, 32'b000000000011);

        // new cfg N=1 D=2 mid high phase: high completes its 4 cycles
        cyc(); cyc(); cyc();
        chk("mid_hi", {31'd0, clk_out}, 32'd1);
        send_cfg(16'd1, 16'd2);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_clk", {31'd0, clk_out}, 32'd1);
        collect(11, co, tk, bz);
        chk("recfg_clk", co, 32'b10011000011);
        chk("recfg_busy", bz, 32'b00000001111);

        // en falls while high: STOP finishes high phase, then IDLE
        en = 1'b0;
        collect(4, co, tk, bz);
        chk("stop_clk", co, 32'b0001);
        chk("stop_busy", bz, 32'b0011);
        chk("stop_rdy", {31'd0, cfg_if.cfg_ready}, 32'd1);
        en = 1'b1;
        collect(5, co, tk, bz);
        chk("restart_clk", co, 32'b01100);
        chk("restart_tick", tk, 32'b00100);

        // illegal configs are discarded, running output continues
        send_cfg(16'd0, 16'd3);
        chk("ill0_busy", {31'd0, busy}, 32'd0);
        chk("ill0_clk", {31'd0, clk_out}, 32'd0);
`ifdef FRAC_DIV_CFG_ERR_EN
        chk("ill0_err", {31'd0, cfg_err}, 32'd1);
`endif
        send_cfg(16'd7, 16'd3);
        chk("ill7_busy", {31'd0, busy}, 32'd0);
        chk("ill7_clk", {31'd0, clk_out}, 32'd1);
`ifdef FRAC_DIV_CFG_ERR_EN
        chk("ill7_err", {31'd0, cfg_err}, 32'd1);
`endif
        collect(4, co, tk, bz);
        chk("ill_clk", co, 32'b1001);
        chk("ill_busy", bz, 32'b0000);

        // legal cfg enters DRAIN, then reset mid-drain
        send_cfg(16'd1, 16'd4);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
`ifdef FRAC_DIV_CFG_ERR_EN
        chk("legal_err", {31'd0, cfg_err}, 32'd0);
`endif
        reset = 1'b1;
        #1;
        chk("mrst_clk", {31'd0, clk_out}, 32'd0);
        chk("mrst_tick", {31'd0, tick}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rdy", {31'd0, cfg_if.cfg_ready}, 32'd0);
        cyc(); cyc();
        reset = 1'b0;
        collect(10, co, tk, bz);
        chk("post_rst_clk", co, 32'd0);
        chk("post_rst_busy", bz, 32'd0);
        chk("post_rst_rdy", {31'd0, cfg_if.cfg_ready}, 32'd1);
        send_cfg(16'd1, 16'd1);
        collect(4, co, tk, bz);
        chk("n1d1_clk", co, 32'b1010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/frac_div_ctrl.md
FRAC_DIV_CTRL -- requirements
Module: frac_div_ctrl

Interface
REQ-001 SHALL provide parameter CW, default 16, width of the numerator and denominator fields.
REQ-002 clk_in  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  run request; high = generate clk_out from loaded config.
REQ-005 cfg_valid  input  1  new config offered.
REQ-006 cfg_ready  output  1  controller can accept config this cycle.
REQ-007 cfg_num  input  CW  numerator N.
REQ-008 cfg_den  input  CW  denominator D.
REQ-009 clk_out  output  1  divided clock, registered; f_out = f_in*N/(2*D).
REQ-010 tick  output  1  one-cycle pulse in the cycle clk_out goes 0->1.
REQ-011 busy  output  1  high in DRAIN, LOAD and STOP states.

Function
REQ-012 Engine SHALL hold acc (CW+1 bits), active N and active D; step: if acc+N >= D then acc <= acc+N-D and clk_out toggles, else acc <= acc+N.
REQ-013 Legal config SHALL be 1 <= N <= D; D = 0 is illegal.
REQ-014 States SHALL be IDLE, RUN, DRAIN, LOAD, STOP; engine steps once per cycle only in RUN, in STOP, and in DRAIN while clk_out = 1.
REQ-015 cfg_ready SHALL be 1 in IDLE and RUN, 0 otherwise; transfer = cfg_valid & cfg_ready, captured into shadow registers.
REQ-016 IDLE: on transfer -> LOAD; else if en & loaded -> RUN; clk_out held 0.
REQ-017 RUN: on transfer -> DRAIN; else if !en -> STOP.
REQ-018 DRAIN: when clk_out = 0 -> LOAD with engine frozen that cycle; else step.
REQ-019 LOAD (exactly one cycle): active N/D <= shadow, acc <= 0, loaded <= 1; next RUN if en, else IDLE.
REQ-020 STOP: step until clk_out = 0, then acc <= 0 and -> IDLE; transfer not possible (cfg_ready = 0).
REQ-021 Simultaneous transfer and en falling in RUN SHALL take DRAIN; LOAD then exits to IDLE.
REQ-022 clk_out SHALL never change in LOAD or IDLE; no high phase is shortened by reconfiguration or stop.
REQ-023 First toggle after LOAD SHALL occur on the step where accumulated N first reaches D.

Reset
REQ-024 Reset SHALL force IDLE, acc = 0, active N/D and shadow = 0, loaded = 0, clk_out = 0, tick = 0, busy = 0, cfg_ready = 0 while reset asserted.
REQ-025 Reset mid-DRAIN/LOAD SHALL discard the pending config; en high after reset does not start without a new LOAD.

Configuration
REQ-026 Macro FRAC_DIV_CFG_ERR_EN defined: adds output cfg_err (1 bit); illegal transfer is accepted, discarded (no state change), and sets cfg_err sticky until next legal transfer or reset.
REQ-027 Macro undefined: no cfg_err port; illegal transfer silently discarded, state unchanged.

Structure
REQ-028 Package frac_div_pkg SHALL hold the state enum, default CW constant and a cfg struct {num, den}.
REQ-029 Sub-module frac_div_core SHALL contain acc, clk_out register and step/clear/load controls; frac_div_ctrl holds FSM, shadow and handshake.

Verification
REQ-030 N=2, D=3, en=1: after LOAD, toggles on steps 2,3,5,6,...; clk_out period 3 cycles average; tick every 3 cycles.
REQ-031 N=5, D=5: clk_out toggles every cycle (period 2); N=1, D=4: period 8, high 4 cycles.
REQ-032 Running N=1, D=4, new cfg N=1, D=2 sent mid high phase: busy high, clk_out completes 4-cycle high, LOAD, then period 4.
REQ-033 en falls with clk_out high: STOP until clk_out low, then IDLE with clk_out 0; en re-raised restarts from acc=0 without reload.
REQ-034 cfg N=0 or N=7, D=3: discarded; with FRAC_DIV_CFG_ERR_EN cfg_err = 1 until legal cfg; prior output unaffected.
REQ-035 reset asserted during DRAIN: all outputs 0 immediately; after release en=1 keeps clk_out 0 until a config transfer.
